// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 4;

    // Round-robin pointer encoding: which source wins when both queues hold work.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // One pending write-back at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Producer handshakes, register-file write port and pending-write mask.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR_W-1:0]    alu_rd;
    logic [DATA_W-1:0]    alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [ADDR_W-1:0]    mem_rd;
    logic [DATA_W-1:0]    mem_data;
    logic                 wb_en;
    logic [ADDR_W-1:0]    wb_rd;
    logic [DATA_W-1:0]    wb_data;
    logic [2**ADDR_W-1:0] busy_mask;

    // Arbiter side: takes producer results, drives the write port.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output wb_en, wb_rd, wb_data, busy_mask
    );

    // Producer / environment side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  wb_en, wb_rd, wb_data, busy_mask
    );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Per-source write-back queue. Exposes every slot's rd and valid bit so the
// top can build the pending-write mask without extra storage.
module regfile_write_arbiter_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_rd,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_rd,
    output logic [DATA_W-1:0]            head_data,
    output logic                         full,
    output logic                         empty,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
    output logic [DEPTH-1:0]             ent_vld
);

    logic [DEPTH-1:0][ADDR_W-1:0] rd_mem_q, rd_mem_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         push_ok;
    logic                         pop_ok;
    logic [PW-1:0]                offset;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign ent_rd    = rd_mem_q;

    // Next storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok) begin
            rd_mem_d[wr_ptr_q]   = push_rd;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ent_vld = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PW'(i) - rd_ptr_q;
            ent_vld[i] = ({1'b0, offset} < count_q);
        end
    end

    // Queue state register; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_mem_q   <= '0;
            data_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side master for the register file: queues ALU and MEM results,
// round-robins between them into a registered write port, and reports
// which registers still have a write in flight.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter bit DROP_R0 = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NREG = 2 ** ADDR_W;

    logic                         alu_push, mem_push;
    logic                         alu_pop, mem_pop;
    logic                         alu_full, mem_full;
    logic                         alu_empty, mem_empty;
    logic [CW-1:0]                alu_cnt, mem_cnt;
    logic [ADDR_W-1:0]            alu_head_rd, mem_head_rd;
    logic [DATA_W-1:0]            alu_head_data, mem_head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_ent_rd, mem_ent_rd;
    logic [DEPTH-1:0]             alu_ent_vld, mem_ent_vld;

    src_e                         rr_q, rr_d;
    logic                         wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]            wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]            wb_data_q, wb_data_d;
    logic [NREG-1:0]              mask;

    // Ready never covers a same-cycle pop; held low throughout reset.
    assign bus.alu_ready = rst & ~alu_full;
    assign bus.mem_ready = rst & ~mem_full;

    // Writes to r0 complete the handshake but are never queued.
    assign alu_push = bus.alu_valid & bus.alu_ready & ~(DROP_R0 && (bus.alu_rd == '0));
    assign mem_push = bus.mem_valid & bus.mem_ready & ~(DROP_R0 && (bus.mem_rd == '0));

    regfile_write_arbiter_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_alu_q (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .push_rd   (bus.alu_rd),
        .push_data (bus.alu_data),
        .pop       (alu_pop),
        .head_rd   (alu_head_rd),
        .head_data (alu_head_data),
        .full      (alu_full),
        .empty     (alu_empty),
        .count     (alu_cnt),
        .ent_rd    (alu_ent_rd),
        .ent_vld   (alu_ent_vld)
    );

    regfile_write_arbiter_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_q (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_push),
        .push_rd   (bus.mem_rd),
        .push_data (bus.mem_data),
        .pop       (mem_pop),
        .head_rd   (mem_head_rd),
        .head_data (mem_head_data),
        .full      (mem_full),
        .empty     (mem_empty),
        .count     (mem_cnt),
        .ent_rd    (mem_ent_rd),
        .ent_vld   (mem_ent_vld)
    );

    // Grant selection: pointer only advances when both sides compete.
    always_comb begin
        alu_pop = 1'b0;
        mem_pop = 1'b0;
        rr_d    = rr_q;
        if (!alu_empty && !mem_empty) begin
            if (rr_q == SRC_ALU) begin
                alu_pop = 1'b1;
            end else begin
                mem_pop = 1'b1;
            end
            rr_d = other_src(rr_q);
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
        end
    end

    // Next write-port contents; idle cycles drive zeros.
    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = '0;
        wb_data_d = '0;
        if (alu_pop) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = alu_head_rd;
            wb_data_d = alu_head_data;
        end else if (mem_pop) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = mem_head_rd;
            wb_data_d = mem_head_data;
        end
    end

    // Round-robin pointer and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= SRC_ALU;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Pending-write mask: every live queue slot plus the write on the port now.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ent_vld[i]) mask[alu_ent_rd[i]] = 1'b1;
            if (mem_ent_vld[i]) mask[mem_ent_rd[i]] = 1'b1;
        end
        if (wb_en_q) mask[wb_rd_q] = 1'b1;
    end

    assign bus.wb_en     = wb_en_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.busy_mask = mask;

    // Occupancy and empty flag must agree in both queues.
    a_cnt_consistent: assert property (
        @(posedge clk) disable iff (!rst)
        ((alu_cnt == '0) == alu_empty) && ((mem_cnt == '0) == mem_empty)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural register_file written by the arbiter's write port.
    logic [31:0] rf     [32] = '{default: 32'h0};
    logic [31:0] exp_rf [32] = '{default: 32'h0};
    always @(posedge clk) if (bus.wb_en) rf[bus.wb_rd] <= bus.wb_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    wb_entry_t   exp_alu [$];
    wb_entry_t   exp_mem [$];
    logic [4:0]  wb_log  [$];
    int          wb_cyc  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every write on the port must be the head of one source's expected queue.
    always @(negedge clk) begin
        wb_entry_t got;
        if (rst === 1'b1 && bus.wb_en === 1'b1) begin
            got.rd   = bus.wb_rd;
            got.data = bus.wb_data;
            checks++;
            if (exp_alu.size() > 0 && exp_alu[0] == got) begin
                void'(exp_alu.pop_front());
                exp_rf[got.rd] = got.data;
            end else if (exp_mem.size() > 0 && exp_mem[0] == got) begin
                void'(exp_mem.pop_front());
                exp_rf[got.rd] = got.data;
            end else begin
                errors++;
                $display("FAIL wb_match actual rd=%0d data=%h expected head of alu(%0d) or mem(%0d) queue",
                         got.rd, got.data, exp_alu.size(), exp_mem.size());
            end
            wb_log.push_back(bus.wb_rd);
            wb_cyc.push_back(cyc);
        end
    end

    // One cycle of stimulus; called between edges, returns 1ns after the edge.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         output logic a_acc, output logic m_acc);
        wb_entry_t e;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
        #1;
        a_acc = av & bus.alu_ready;
        m_acc = mv & bus.mem_ready;
        @(posedge clk);
        if (a_acc && ard != 5'd0) begin
            e.rd = ard; e.data = ad; exp_alu.push_back(e);
        end
        if (m_acc && mrd != 5'd0) begin
            e.rd = mrd; e.data = md; exp_mem.push_back(e);
        end
        #1;
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a, m;
        repeat (n) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a, m);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_alu.size() + exp_mem.size() != 0 || bus.wb_en) && k < 40) begin
            idle(1);
            k++;
        end
        idle(1);
        chk({name, "_drained"}, 32'(exp_alu.size() + exp_mem.size()), 32'd0);
    endtask

    logic [4:0] seq2 [8] = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};

    initial begin
        logic a_acc, m_acc;
        int   ai, mi, w;
        logic seen, saw_bp;

        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_wb_en",     32'(bus.wb_en),     32'd0);
        chk("rst_wb_rd",     32'(bus.wb_rd),     32'd0);
        chk("rst_wb_data",   bus.wb_data,        32'd0);
        chk("rst_busy",      bus.busy_mask,      32'd0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rel_mem_ready", 32'(bus.mem_ready), 32'd1);

        // Round-robin from reset
        wb_log.delete(); wb_cyc.delete();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 5'(i + 1), 32'h1100_0000 + 32'(i), 1'b1, 5'(i + 5), 32'h5500_0000 + 32'(i), a_acc, m_acc);
        drain("rr");
        chk("rr_count", 32'(wb_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < wb_log.size()) chk($sformatf("rr_seq%0d", i), 32'(wb_log[i]), 32'(seq2[i]));
        if (wb_cyc.size() == 8) chk("rr_continuous", 32'(wb_cyc[7] - wb_cyc[0]), 32'd7);

        // Single write latency and mask lifetime
        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, a_acc, m_acc);
        chk("single_acc",    32'(a_acc),             32'd1);
        chk("single_e1_en",  32'(bus.wb_en),         32'd0);
        chk("single_e1_bsy", 32'(bus.busy_mask[3]),  32'd1);
        idle(1);
        chk("single_e2_en",  32'(bus.wb_en),         32'd1);
        chk("single_e2_rd",  32'(bus.wb_rd),         32'd3);
        chk("single_e2_dat", bus.wb_data,            32'hDEAD_BEEF);
        chk("single_e2_bsy", 32'(bus.busy_mask[3]),  32'd1);
        idle(1);
        chk("single_e3_en",  32'(bus.wb_en),         32'd0);
        chk("single_e3_bsy", 32'(bus.busy_mask[3]),  32'd0);
        chk("single_rs3",    rf[3],                  32'hDEAD_BEEF);

        // R0 drop
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234_5678, a_acc, m_acc);
        chk("r0_handshake", 32'(m_acc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("r0_busy%0d", i), 32'(bus.busy_mask[0]), 32'd0);
            chk($sformatf("r0_en%0d", i),   32'(bus.wb_en),        32'd0);
            idle(1);
        end

        // Reset mid-operation
        drive(1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0, 32'h0, a_acc, m_acc);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hAAAA_AAAA;
        #1;
        chk("rmid_ready", 32'(bus.alu_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_alu.delete(); exp_mem.delete();
        bus.alu_valid = 1'b0;
        #1;
        chk("rmid_wb_en",     32'(bus.wb_en),     32'd0);
        chk("rmid_busy",      bus.busy_mask,      32'd0);
        chk("rmid_alu_ready", 32'(bus.alu_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rmid_rel_ready", 32'(bus.alu_ready), 32'd1);
        idle(3);
        chk("rmid_wb_en2", 32'(bus.wb_en), 32'd0);
        chk("rmid_r9",     rf[9],          exp_rf[9]);
        chk("rmid_r10",    rf[10],         exp_rf[10]);
        drive(1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0, 32'h0, a_acc, m_acc);
        drain("rmid");
        chk("rmid_after", rf[9], 32'h0909_0909);

        // Issue gated by busy_mask
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_0000, a_acc, m_acc);
        seen = bus.busy_mask[7];
        w = 0;
        while (bus.busy_mask[7] && w < 10) begin
            idle(1);
            w++;
        end
        chk("mask_seen",   32'(seen),     32'd1);
        chk("mask_bound",  32'(w < 10),   32'd1);
        chk("mask_mem_r7", rf[7],         32'h7777_0000);
        drive(1'b1, 5'd7, 32'hA1A1_0007, 1'b0, 5'd0, 32'h0, a_acc, m_acc);
        drain("mask");
        chk("mask_final_r7", rf[7], 32'hA1A1_0007);

        // Backpressure: both sources hold data until accepted, 20 cycles
        wb_log.delete(); wb_cyc.delete();
        ai = 0; mi = 0; saw_bp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'(11 + ai % 5), 32'hA000_0000 + 32'(ai),
                  1'b1, 5'(16 + mi % 8), 32'hB000_0000 + 32'(mi), a_acc, m_acc);
            if (!a_acc || !m_acc) saw_bp = 1'b1;
            if (a_acc) ai++;
            if (m_acc) mi++;
        end
        drain("bp");
        chk("bp_seen",  32'(saw_bp),        32'd1);
        chk("bp_count", 32'(wb_log.size()), 32'(ai + mi));
        for (int r = 1; r < 32; r++) chk($sformatf("final_r%0d", r), rf[r], exp_rf[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
